// File: rtl/led_out_queue.sv
// Bus-mapped LED output: CPU-written patterns queue in a small FIFO and are
// shown one after another, each for a programmable number of milliseconds.
module led_out_queue #(
   parameter int unsigned     BITS     = 32,
   parameter int unsigned     LED_BITS = 10,
   parameter logic [BITS-1:0] BASE     = 32'hFFFF_F000,
   parameter int unsigned     DEPTH    = 4,
   parameter int unsigned     MS_TICKS = 96000
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [BITS-1:0]     ABUS,
   inout  wire  [BITS-1:0]     DBUS,
   input  logic                WE,
   output logic [LED_BITS-1:0] OUTPUT,
   output logic                INTR
);
   // state  | meaning
   // S_IDLE | nothing on display timer; OUTPUT holds the last pattern
   // S_SHOW | a pattern is being held for hold_q milliseconds
   typedef enum logic {S_IDLE, S_SHOW} state_t;

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = (MS_TICKS > 1) ? $clog2(MS_TICKS) : 1;
   localparam logic [BITS-1:0] A_LDATA = BASE;
   localparam logic [BITS-1:0] A_LCTRL = BASE + BITS'(4);
   localparam logic [BITS-1:0] A_LHOLD = BASE + BITS'(8);

   state_t                state_q, state_d;
   logic [LED_BITS-1:0]   mem_q [DEPTH];
   logic [AW-1:0]         rd_ptr_q, wr_ptr_q;
   logic [AW:0]           count_q;
   logic [LED_BITS-1:0]   out_q;
   logic [PW-1:0]         presc_q;
   logic [15:0]           hold_q;
   logic [15:0]           lhold_q;
   logic                  ovr_q, ie_q;

   logic hit_data, hit_ctrl, hit_hold;
   logic wr_data, wr_ctrl, wr_hold;
   logic full, empty, push, pop, presc_wrap, hold_last, idle;
   logic [BITS-1:0] rdata;

   assign hit_data   = (ABUS == A_LDATA);
   assign hit_ctrl   = (ABUS == A_LCTRL);
   assign hit_hold   = (ABUS == A_LHOLD);
   assign wr_data    = WE & hit_data;
   assign wr_ctrl    = WE & hit_ctrl;
   assign wr_hold    = WE & hit_hold;

   assign full       = (count_q == (AW+1)'(DEPTH));
   assign empty      = (count_q == '0);
   assign push       = wr_data & ~full;
   assign presc_wrap = (presc_q == PW'(MS_TICKS - 1));
   assign hold_last  = (hold_q == 16'd1);
   assign idle       = (state_q == S_IDLE) & empty;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (!empty) state_d = S_SHOW;
         S_SHOW:  if (presc_wrap && hold_last && empty) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Expiry with a queued pattern reloads directly, so there is no gap cycle.
   always_comb begin
      pop = 1'b0;
      case (state_q)
         S_IDLE:  pop = ~empty;
         S_SHOW:  pop = presc_wrap & hold_last & ~empty;
         default: pop = 1'b0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (push) mem_q[wr_ptr_q] <= DBUS[LED_BITS-1:0];
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (push && !pop)      count_q <= count_q + (AW+1)'(1);
         else if (pop && !push) count_q <= count_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         out_q   <= '0;
         presc_q <= '0;
         hold_q  <= '0;
      end else if (pop) begin
         out_q   <= mem_q[rd_ptr_q];
         presc_q <= '0;
         hold_q  <= (lhold_q == '0) ? 16'd1 : lhold_q;
      end else if (state_q == S_SHOW) begin
         presc_q <= presc_wrap ? '0 : presc_q + PW'(1);
         if (presc_wrap) hold_q <= hold_q - 16'd1;
      end
   end

   // An overflowing data write outranks a clearing control write.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ovr_q   <= 1'b0;
         ie_q    <= 1'b0;
         lhold_q <= 16'd1;
      end else begin
         if (wr_data && full)           ovr_q <= 1'b1;
         else if (wr_ctrl && !DBUS[1])  ovr_q <= 1'b0;
         if (wr_ctrl) ie_q    <= DBUS[4];
         if (wr_hold) lhold_q <= DBUS[15:0];
      end
   end

   always_comb begin
      rdata = '0;
      if (hit_data) begin
         rdata[LED_BITS-1:0] = out_q;
      end else if (hit_ctrl) begin
         rdata[0] = ~full;
         rdata[1] = ovr_q;
         rdata[2] = idle;
         rdata[4] = ie_q;
      end else if (hit_hold) begin
         rdata[15:0] = lhold_q;
      end
   end

   assign DBUS   = (!WE && (hit_data || hit_ctrl || hit_hold)) ? rdata : {BITS{1'bz}};
   assign OUTPUT = out_q;
   assign INTR   = ~full & ie_q;

endmodule

// File: tb/tb_led_out_queue.sv
// Bench for led_out_queue: random and directed bus traffic compared against
// a queue-and-countdown model of the LED display.
module tb_led_out_queue;
   localparam int MS    = 10;
   localparam int DEPTH = 4;
   localparam logic [31:0] BASE   = 32'hFFFF_F000;
   localparam logic [31:0] A_DATA = BASE;
   localparam logic [31:0] A_CTRL = BASE + 32'd4;
   localparam logic [31:0] A_HOLD = BASE + 32'd8;
   localparam logic [31:0] A_IDLE = 32'h0000_0100;

   logic        clk, rst, we, drv;
   logic [31:0] abus, dout;
   wire  [31:0] dbus;
   logic [9:0]  led;
   logic        intr;

   assign dbus = drv ? dout : 'z;

   led_out_queue #(.BITS(32), .LED_BITS(10), .BASE(BASE), .DEPTH(DEPTH), .MS_TICKS(MS)) dut (
      .CLK(clk), .RST(rst), .ABUS(abus), .DBUS(dbus), .WE(we), .OUTPUT(led), .INTR(intr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Model: pending patterns, the pattern on display, cycles left before the
   // next load (0 = idle), and the register bits.
   logic [9:0]  q[$];
   logic [9:0]  m_disp;
   int          m_rem;
   bit          m_ovr, m_ie;
   logic [15:0] m_hold;

   function automatic logic [31:0] m_lctrl();
      logic [31:0] v;
      v    = '0;
      v[0] = (q.size() < DEPTH);
      v[1] = m_ovr;
      v[2] = (m_rem == 0) && (q.size() == 0);
      v[4] = m_ie;
      return v;
   endfunction

   function automatic logic m_intr();
      return (q.size() < DEPTH) && m_ie;
   endfunction

   task automatic model_reset();
      q.delete();
      m_disp = '0;
      m_rem  = 0;
      m_ovr  = 1'b0;
      m_ie   = 1'b0;
      m_hold = 16'd1;
   endtask

   // Advance one clock: the model consumes the inputs present before the edge.
   task automatic step();
      bit full;
      int d;
      full = (q.size() == DEPTH);
      d    = ((m_hold == 16'd0) ? 1 : int'(m_hold)) * MS;
      if (m_rem == 0) begin
         if (q.size() > 0) begin m_disp = q.pop_front(); m_rem = d; end
      end else if (m_rem == 1) begin
         if (q.size() > 0) begin m_disp = q.pop_front(); m_rem = d; end
         else m_rem = 0;
      end else begin
         m_rem = m_rem - 1;
      end
      if (we && abus == A_DATA) begin
         if (!full) q.push_back(dout[9:0]);
         else       m_ovr = 1'b1;
      end else if (we && abus == A_CTRL) begin
         m_ie = dout[4];
         if (!dout[1]) m_ovr = 1'b0;
      end else if (we && abus == A_HOLD) begin
         m_hold = dout[15:0];
      end
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      abus = a; dout = d; we = 1'b1; drv = 1'b1;
      step();
      we = 1'b0; drv = 1'b0; abus = A_IDLE; dout = '0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
      abus = a; we = 1'b0; drv = 1'b0;
      #1;
      v = dbus;
      abus = A_IDLE;
   endtask

   task automatic do_reset();
      we = 1'b0; drv = 1'b0; abus = A_IDLE; dout = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      logic [31:0] v;
      logic [31:0] addrs [3];
      do_reset();
      checks++; if (led !== 10'h0) begin failures++; $display("FAIL reset_output: got %0h expected 0", led); end
      checks++; if (intr !== 1'b0) begin failures++; $display("FAIL reset_intr: got %0b expected 0", intr); end
      bus_read(A_CTRL, v);
      checks++; if (v !== 32'h5) begin failures++; $display("FAIL reset_lctrl: got %0h expected 5", v); end
      bus_read(A_HOLD, v);
      checks++; if (v !== 32'h1) begin failures++; $display("FAIL reset_lhold: got %0h expected 1", v); end
      bus_read(A_DATA, v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL reset_ldata: got %0h expected 0", v); end
      // With the bench driving zeros on an unmapped read, any DUT drive would corrupt the bus.
      addrs[0] = A_IDLE; addrs[1] = BASE + 32'd12; addrs[2] = BASE - 32'd4;
      for (int i = 0; i < 3; i++) begin
         abus = addrs[i]; we = 1'b0; dout = '0; drv = 1'b1;
         #1;
         checks++; if (dbus !== 32'h0) begin failures++; $display("FAIL dbus_float addr=%0h: got %0h expected 0", addrs[i], dbus); end
         drv = 1'b0; abus = A_IDLE;
      end
   endtask

   task automatic test_single_hold();
      logic [31:0] v;
      int n;
      do_reset();
      bus_write(A_HOLD, 32'd2);
      bus_write(A_DATA, 32'h155);
      checks++; if (led !== 10'h0) begin failures++; $display("FAIL single_before_load: got %0h expected 0", led); end
      step();
      checks++; if (led !== 10'h155) begin failures++; $display("FAIL single_load: got %0h expected 155", led); end
      n = 0;
      bus_read(A_CTRL, v);
      while (v[2] !== 1'b1 && n < 60) begin
         step();
         n++;
         checks++; if (led !== m_disp) begin failures++; $display("FAIL single_output cyc=%0d: got %0h expected %0h", n, led, m_disp); end
         bus_read(A_CTRL, v);
      end
      checks++; if (n != 20) begin failures++; $display("FAIL single_hold_len: got %0d expected 20", n); end
      repeat (5) step();
      checks++; if (led !== 10'h155) begin failures++; $display("FAIL single_idle_hold: got %0h expected 155", led); end
      bus_read(A_CTRL, v);
      checks++; if (v !== m_lctrl()) begin failures++; $display("FAIL single_idle_lctrl: got %0h expected %0h", v, m_lctrl()); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] v;
      int cnt2, first2, first3;
      do_reset();
      bus_write(A_HOLD, 32'd1);
      bus_write(A_DATA, 32'h1);
      bus_write(A_DATA, 32'h2);
      bus_write(A_DATA, 32'h3);
      cnt2 = 0; first2 = -1; first3 = -1;
      for (int t = 0; t < 40; t++) begin
         step();
         checks++; if (led !== m_disp) begin failures++; $display("FAIL b2b_output t=%0d: got %0h expected %0h", t, led, m_disp); end
         bus_read(A_DATA, v);
         checks++; if (v !== {22'h0, m_disp}) begin failures++; $display("FAIL b2b_ldata t=%0d: got %0h expected %0h", t, v, m_disp); end
         if (led == 10'h2) begin cnt2++; if (first2 < 0) first2 = t; end
         if (led == 10'h3 && first3 < 0) first3 = t;
      end
      checks++; if (cnt2 != 10) begin failures++; $display("FAIL b2b_len2: got %0d expected 10", cnt2); end
      checks++; if (first3 - first2 != 10) begin failures++; $display("FAIL b2b_step: got %0d expected 10", first3 - first2); end
   endtask

   task automatic test_overrun();
      logic [31:0] v;
      logic [9:0]  vals [6];
      int n;
      do_reset();
      bus_write(A_HOLD, 32'd5);
      for (int i = 0; i < 6; i++) begin
         vals[i] = 10'($urandom_range(1, 1023));
         bus_write(A_DATA, {22'h0, vals[i]});
      end
      bus_read(A_CTRL, v);
      checks++; if (v !== 32'h2) begin failures++; $display("FAIL ovr_set: got %0h expected 2", v); end
      bus_write(A_CTRL, 32'h2);
      bus_read(A_CTRL, v);
      checks++; if (v !== 32'h2) begin failures++; $display("FAIL ovr_write1: got %0h expected 2", v); end
      bus_write(A_CTRL, 32'h0);
      bus_read(A_CTRL, v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL ovr_clear: got %0h expected 0", v); end
      n = 0;
      bus_read(A_CTRL, v);
      while (v[2] !== 1'b1 && n < 400) begin
         step();
         n++;
         checks++; if (led !== m_disp) begin failures++; $display("FAIL ovr_drain cyc=%0d: got %0h expected %0h", n, led, m_disp); end
         bus_read(A_CTRL, v);
      end
      checks++; if (v[2] !== 1'b1) begin failures++; $display("FAIL ovr_drain_timeout: got idle=%0b expected 1", v[2]); end
      checks++; if (led !== vals[4]) begin failures++; $display("FAIL ovr_last_shown: got %0h expected %0h", led, vals[4]); end
   endtask

   task automatic test_intr();
      logic [31:0] v;
      int n;
      do_reset();
      bus_write(A_CTRL, 32'h10);
      bus_write(A_HOLD, 32'd3);
      for (int i = 0; i < 5; i++) bus_write(A_DATA, 32'($urandom_range(0, 1023)));
      checks++; if (intr !== 1'b0) begin failures++; $display("FAIL intr_full: got %0b expected 0", intr); end
      n = 0;
      while (intr !== 1'b1 && n < 100) begin
         step();
         n++;
         checks++; if (intr !== m_intr()) begin failures++; $display("FAIL intr_track cyc=%0d: got %0b expected %0b", n, intr, m_intr()); end
      end
      checks++; if (intr !== 1'b1) begin failures++; $display("FAIL intr_timeout: got %0b expected 1", intr); end
      bus_read(A_CTRL, v);
      checks++; if (v[0] !== 1'b1) begin failures++; $display("FAIL intr_ready: got %0b expected 1", v[0]); end
      bus_write(A_CTRL, 32'h0);
      checks++; if (intr !== 1'b0) begin failures++; $display("FAIL intr_disable: got %0b expected 0", intr); end
   endtask

   task automatic test_zero_hold_and_reset();
      logic [31:0] v;
      logic [9:0]  p;
      int n;
      do_reset();
      bus_write(A_HOLD, 32'd0);
      p = 10'($urandom_range(1, 1023));
      bus_write(A_DATA, {22'h0, p});
      step();
      checks++; if (led !== p) begin failures++; $display("FAIL zero_load: got %0h expected %0h", led, p); end
      n = 0;
      bus_read(A_CTRL, v);
      while (v[2] !== 1'b1 && n < 60) begin
         step();
         n++;
         bus_read(A_CTRL, v);
      end
      checks++; if (n != 10) begin failures++; $display("FAIL zero_hold_len: got %0d expected 10", n); end
      bus_write(A_DATA, 32'h3C3);
      step();
      repeat (5) step();
      checks++; if (led !== 10'h3C3) begin failures++; $display("FAIL rst_pre: got %0h expected 3c3", led); end
      rst = 1'b1;
      #1;
      checks++; if (led !== 10'h0) begin failures++; $display("FAIL rst_async_output: got %0h expected 0", led); end
      bus_read(A_CTRL, v);
      checks++; if (v !== 32'h5) begin failures++; $display("FAIL rst_lctrl: got %0h expected 5", v); end
      bus_read(A_HOLD, v);
      checks++; if (v !== 32'h1) begin failures++; $display("FAIL rst_lhold: got %0h expected 1", v); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_random();
      logic [31:0] v;
      int r;
      do_reset();
      for (int t = 0; t < 600; t++) begin
         r = $urandom_range(0, 99);
         if (r < 30)      bus_write(A_DATA, $urandom);
         else if (r < 35) bus_write(A_CTRL, $urandom);
         else if (r < 40) bus_write(A_HOLD, 32'($urandom_range(0, 3)) | ($urandom & 32'hFFFF_0000));
         else             step();
         checks++; if (led !== m_disp) begin failures++; $display("FAIL rnd_output t=%0d: got %0h expected %0h", t, led, m_disp); end
         checks++; if (intr !== m_intr()) begin failures++; $display("FAIL rnd_intr t=%0d: got %0b expected %0b", t, intr, m_intr()); end
         bus_read(A_CTRL, v);
         checks++; if (v !== m_lctrl()) begin failures++; $display("FAIL rnd_lctrl t=%0d: got %0h expected %0h", t, v, m_lctrl()); end
         bus_read(A_HOLD, v);
         checks++; if (v !== {16'h0, m_hold}) begin failures++; $display("FAIL rnd_lhold t=%0d: got %0h expected %0h", t, v, m_hold); end
      end
   endtask

   initial begin
      rst = 1'b1; we = 1'b0; drv = 1'b0; abus = A_IDLE; dout = '0;
      model_reset();
      test_reset();
      test_single_hold();
      test_back_to_back();
      test_overrun();
      test_intr();
      test_zero_hold_and_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/led_out_queue.md
# led_out_queue

Memory-mapped output port that drives the board LEDs from the CPU data bus. The CPU writes LED patterns into a small FIFO. The block shows each pattern for a programmable number of milliseconds, then moves to the next one. Ready, Overrun and IE semantics match the switch input device, and the block sits on the same ABUS/DBUS/WE bus with its own interrupt line.

## Interface
- BITS, 32, bus width of ABUS/DBUS
- LED_BITS, 10, width of OUTPUT
- BASE, 32'hFFFFF000, address of LDATA; LCTRL = BASE+4, LHOLD = BASE+8
- DEPTH, 4, FIFO entries (power of two, ≥2)
- MS_TICKS, 96000, CLK cycles per millisecond (96 MHz PLL)

Ports:
- CLK  in  1  clock; all state changes on posedge
- RST  in  1  reset, asynchronous, active-high
- ABUS  in  BITS  address bus
- DBUS  inout  BITS  data bus; driven only on reads of own addresses, else all-Z
- WE  in  1  1 = write cycle, 0 = read cycle
- OUTPUT  out  LED_BITS  displayed pattern (registered)
- INTR  out  1  LCTRL[0] & LCTRL[4]

## Operation
- LDATA write: pushes DBUS[LED_BITS-1:0] into the FIFO. If the FIFO is full, the data is dropped and LCTRL[1] (Overrun) is set.
- LDATA read: returns OUTPUT, zero-extended to BITS.
- LCTRL bits:
  - [0] Ready = FIFO not full (read-only).
  - [1] Overrun; a write of 0 clears it, a write of 1 is ignored.
  - [2] Idle = state IDLE and FIFO empty (read-only).
  - [4] IE (read/write).
  - All other bits read 0.
- LHOLD: [15:0] hold time in ms, read/write, upper bits read 0. A value of 0 is treated as 1.
- Each LCTRL/LHOLD access (read or write) is a single-cycle access.

FSM:
- IDLE: if the FIFO is non-empty, pop the head into OUTPUT, load hold_cnt = max(LHOLD,1), clear the prescaler, go to SHOW.
- SHOW:
  - The prescaler counts 0..MS_TICKS-1. On wrap, hold_cnt decrements.
  - When hold_cnt hits 0 on a wrap: if the FIFO is non-empty, pop, reload and stay in SHOW in that same cycle. Otherwise go to IDLE.
- OUTPUT holds the last pattern indefinitely in IDLE.
- Pointers: log2(DEPTH)-bit rd/wr pointers plus a count register of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.

## Timing
- Reset values: OUTPUT=0, FIFO empty, state IDLE, LCTRL=0x5 (Ready=1, Idle=1), LHOLD=1, prescaler=0, hold_cnt=0, INTR=0, DBUS=Z.
- A write accepted at edge N is visible in the FIFO after N. From IDLE, OUTPUT updates at edge N+1. Idle and Ready reflect the new count from edge N.
- Each pattern is displayed for exactly max(LHOLD,1)·MS_TICKS cycles, measured from its load edge to the next load edge.
- Full is evaluated before the edge:
  - A write while full is dropped even if a pop occurs on the same edge.
  - A push and a pop on the same edge when not full leave the count unchanged.
- A write to LHOLD during SHOW affects only the next load.
- A write of 0 to Overrun on the same edge as an overflowing write: the set wins, Overrun = 1.
- Reads are combinational: DBUS is valid in the same cycle ABUS matches with WE=0.
- Asserting RST mid-SHOW immediately clears all state to the reset values; OUTPUT goes to 0 asynchronously.

## Test plan
(bench MS_TICKS=10, DEPTH=4)
- Reset → OUTPUT=0, LCTRL read 0x5, LHOLD read 1, INTR=0, DBUS=Z when no address matches.
- LHOLD=2, write 0x155 → OUTPUT=0x155 one cycle after the write edge, held 20 cycles; then Idle=1 and OUTPUT stays 0x155.
- LHOLD=1, back-to-back writes 0x1, 0x2, 0x3 → OUTPUT steps 0x1→0x2→0x3 at 10-cycle intervals with no gap cycle; LDATA reads track OUTPUT.
- Write 6 patterns while SHOW holds (first pops at once) → 5 accepted, 6th dropped, Ready=0, Overrun=1. Write LCTRL=0x2 → Overrun stays 1; write LCTRL=0x0 → Overrun=0.
- IE=1, FIFO full → INTR=0; after the first pop Ready=1 and INTR=1; IE=0 → INTR=0.
- LHOLD=0 with one write → pattern held 10 cycles. Assert RST at cycle 5 of SHOW → OUTPUT=0, LCTRL=0x5 immediately.
